// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier built around a 32-bit ripple-carry adder.
// Optional macro ZERO_BYPASS_EN: a zero operand at accept goes straight to DONE with product 0.

module rca_adder32 #(
    parameter int WIDTH = 32
) (
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin
);
    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign sum[gi]       = x[gi] ^ y[gi] ^ w_carry[gi];
        assign w_carry[gi+1] = (x[gi] & y[gi]) | (w_carry[gi] & (x[gi] ^ y[gi]));
    end

    assign cout = w_carry[WIDTH];
endmodule

module seq_shift_add_mult #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [1:0]         o_dbg_state
);
    // Handshakes: a transfer happens on a posedge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and product is held until taken.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [5:0]         r_count;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0] w_shifted;
    logic               w_last_iter;

    assign w_addend    = r_acc_lo[0] ? r_mcand : '0;
    assign w_shifted   = {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};
    assign w_last_iter = (r_count == 6'd31);

    rca_adder32 #(.WIDTH(WIDTH)) u_adder (
        .sum  (w_sum),
        .cout (w_cout),
        .x    (r_acc_hi),
        .y    (w_addend),
        .cin  (1'b0)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef ZERO_BYPASS_EN
                    if ((a == '0) || (b == '0)) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = RUN;
                    end
`else
                    w_next_state = RUN;
`endif
                end
            end
            RUN: begin
                if (w_last_iter) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // The carry joins the shifted accumulator so the 33-bit partial sum is never truncated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand   <= a;
                        r_acc_hi  <= '0;
                        r_acc_lo  <= b;
                        r_count   <= '0;
                        r_product <= '0;
                    end
                end
                RUN: begin
                    {r_acc_hi, r_acc_lo} <= w_shifted;
                    r_count              <= r_count + 6'd1;
                    if (w_last_iter) begin
                        r_product <= w_shifted;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_product <= '0;
                    end
                end
                default: r_product <= '0;
            endcase
        end
    end

    assign product     = r_product;
    assign o_dbg_state = r_state;
endmodule
